// File: rtl/qpu_ifu_ift2icb_mo_pkg.sv
// Shared widths for the IFU fetch-to-ICB bridge.
// Widths that derive from these (lane bytes, offset bits) live in the bridge.
package qpu_ifu_ift2icb_mo_pkg;

    localparam int QPU_PC_SIZE         = 16;
    localparam int QPU_ITCM_ADDR_WIDTH = 16;
    localparam int QPU_ITCM_DATA_WIDTH = 64;
    localparam int QPU_IFU_OUTS        = 2;

endpackage

// File: rtl/qpu_ifu_ift2icb_mo_trkfifo.sv
// Tracking FIFO for outstanding fetches.
// Bit 0 of each entry is the discard mark, which a flush sets on every live entry.
module qpu_ifu_ift2icb_mo_trkfifo #(
    parameter int DP = 2,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    input  logic          flush_mark_i,
    output logic [DW-1:0] head_dat_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;

    logic [DW-1:0] mem_q [DP];
    logic [DP-1:0] vld_q;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DP; i++) mem_q[i] <= '0;
        end else begin
            if (flush_mark_i) begin
                for (int i = 0; i < DP; i++) begin
                    if (vld_q[i]) mem_q[i][0] <= 1'b1;
                end
            end
            if (push_i) begin
                mem_q[wptr_q] <= push_dat_i;
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop_i) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= ptr_inc(rptr_q);
            end
        end
    end

    assign head_dat_o = mem_q[rptr_q];
    assign empty_o    = ~vld_q[rptr_q];
    assign full_o     = vld_q[wptr_q];

endmodule

// File: rtl/qpu_ifu_ift2icb_mo.sv
// IFU fetch requests to ICB bus, multiple outstanding, in-order responses.
// Sequential fetches into an unchanged lane are served from the lane register.
module qpu_ifu_ift2icb_mo
    import qpu_ifu_ift2icb_mo_pkg::*;
#(
    parameter int PC_W   = QPU_PC_SIZE,
    parameter int ADDR_W = QPU_ITCM_ADDR_WIDTH,
    parameter int DATA_W = QPU_ITCM_DATA_WIDTH,
    parameter int OUTS   = QPU_IFU_OUTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [PC_W-1:0]   ifu_req_pc,
    input  logic              ifu_req_seq,
    input  logic              ifu_flush,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [31:0]       ifu_rsp_instr,
    output logic              ifu_rsp_err,
    output logic              ifu_icb_cmd_valid,
    input  logic              ifu_icb_cmd_ready,
    output logic [ADDR_W-1:0] ifu_icb_cmd_addr,
    input  logic              ifu_icb_rsp_valid,
    output logic              ifu_icb_rsp_ready,
    input  logic [DATA_W-1:0] ifu_icb_rsp_rdata,
    input  logic              ifu_icb_rsp_err,
    input  logic              ifu_holdup,
    input  logic              itcm_nohold
);

    localparam int LB     = $clog2(DATA_W / 8);
    localparam int OFF_W  = $clog2(DATA_W / 32);
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
    localparam int TAG_W  = PC_W - LB;
    localparam int DW     = OFF_WS + 2;

    logic [DATA_W-1:0] lane_q, lane_d;
    logic              lane_vld_q, lane_vld_d;
    logic [TAG_W-1:0]  last_tag_q, last_tag_d;

    logic [TAG_W-1:0]  req_tag;
    logic [OFF_WS-1:0] req_off;
    logic              zuop;
    logic              push, pop, cmd_hs, icb_hs;
    logic [DW-1:0]     head_dat;
    logic              fifo_empty, fifo_full;
    logic              head_vld, head_zuop, head_disc;
    logic [OFF_WS-1:0] head_off;
    logic              unused_pc;

    assign req_tag   = ifu_req_pc[PC_W-1:LB];
    assign unused_pc = ^ifu_req_pc[1:0];

    if (OFF_W > 0) begin : g_off
        assign req_off = ifu_req_pc[LB-1:2];
    end else begin : g_nooff
        assign req_off = 1'b0;
    end

    assign zuop = ifu_req_seq & lane_vld_q & (req_tag == last_tag_q)
                & ifu_holdup & ~itcm_nohold;

    assign ifu_icb_cmd_valid = ~rst & ifu_req_valid & ~fifo_full
                             & ~ifu_flush & ~zuop;
    assign ifu_req_ready     = ~rst & ~fifo_full & ~ifu_flush
                             & (zuop | ifu_icb_cmd_ready);
    assign ifu_icb_cmd_addr  = {ifu_req_pc[ADDR_W-1:LB], {LB{1'b0}}};

    assign push   = ifu_req_valid & ifu_req_ready;
    assign cmd_hs = ifu_icb_cmd_valid & ifu_icb_cmd_ready;

    assign head_vld  = ~rst & ~fifo_empty;
    assign head_off  = head_dat[DW-1:2];
    assign head_zuop = head_dat[1];
    assign head_disc = head_dat[0];

    assign ifu_icb_rsp_ready = head_vld & ~head_zuop
                             & (ifu_rsp_ready | head_disc);
    assign icb_hs = ifu_icb_rsp_valid & ifu_icb_rsp_ready;

    // Zero-uop entries retire without touching the bus.
    assign pop = icb_hs
               | (head_vld & head_zuop & (head_disc | ifu_rsp_ready));

    always_comb begin
        ifu_rsp_valid = 1'b0;
        ifu_rsp_instr = ifu_icb_rsp_rdata[{head_off, 5'd0} +: 32];
        ifu_rsp_err   = 1'b0;
        if (head_vld && !head_disc) begin
            if (head_zuop) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_instr = lane_q[{head_off, 5'd0} +: 32];
            end else begin
                ifu_rsp_valid = ifu_icb_rsp_valid;
                ifu_rsp_err   = ifu_icb_rsp_err;
            end
        end
    end

    always_comb begin
        lane_d     = lane_q;
        lane_vld_d = lane_vld_q;
        last_tag_d = last_tag_q;
        if (icb_hs) begin
            lane_d     = ifu_icb_rsp_rdata;
            lane_vld_d = ~ifu_icb_rsp_err;
        end
        if (ifu_flush) lane_vld_d = 1'b0;
        if (cmd_hs) last_tag_d = req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q     <= '0;
            lane_vld_q <= 1'b0;
            last_tag_q <= '0;
        end else begin
            lane_q     <= lane_d;
            lane_vld_q <= lane_vld_d;
            last_tag_q <= last_tag_d;
        end
    end

    qpu_ifu_ift2icb_mo_trkfifo #(
        .DP (OUTS),
        .DW (DW)
    ) u_trkfifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_dat_i   ({req_off, zuop, 1'b0}),
        .pop_i        (pop),
        .flush_mark_i (ifu_flush),
        .head_dat_o   (head_dat),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

endmodule
